// File: rtl/dual_edge_pkg.sv
// Shared definitions for the dual-edge counter and its checker.
// Holds the checker state encoding and the default counter geometry.
package dual_edge_pkg;

    localparam int DEC_WIDTH = 4;
    localparam int DEC_STEP  = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED,
        ERR
    } chk_state_t;

endpackage

// File: rtl/dual_edge_count_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over an increment in the same cycle.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = &r_cnt;
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dual_edge_count_checker.sv
// Checker for the dual-edge counter: locks onto a fixed per-clk step,
// flags sequence errors and wraps, and keeps saturating event counts.
module dual_edge_count_checker
    import dual_edge_pkg::*;
#(
    parameter int WIDTH    = DEC_WIDTH,
    parameter int STEP     = DEC_STEP,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_delta
);

    chk_state_t       r_state;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_good;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_wrap_pulse;
    logic [WIDTH-1:0] r_last_delta;

    logic [WIDTH-1:0] w_delta;
    logic             w_ok;
    logic             w_wrap;
    logic [3:0]       w_good_nx;
    logic             w_lock_hit;
    logic             w_in_lock;
    logic             w_err_ev;
    logic             w_wrap_ev;

    assign w_delta    = cnt_in - r_prev;
    assign w_ok       = (w_delta == WIDTH'(STEP));
    assign w_wrap     = (cnt_in < r_prev);
    assign w_good_nx  = r_good + 4'd1;
    assign w_lock_hit = (w_good_nx == 4'(LOCK_CNT));
    assign w_in_lock  = cnt_valid && (r_state == LOCKED);
    assign w_err_ev   = w_in_lock && !w_ok;
    assign w_wrap_ev  = w_in_lock && w_ok && w_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_prev       <= '0;
            r_good       <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_last_delta <= '0;
        end else begin
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            if (!cnt_valid) begin
                // Counter in reset or stopped: drop back quietly.
                r_state  <= IDLE;
                r_locked <= 1'b0;
            end else begin
                if (r_state != IDLE) begin
                    r_last_delta <= w_delta;
                end
                r_prev <= cnt_in;
                unique case (r_state)
                    IDLE: begin
                        r_good   <= '0;
                        r_locked <= 1'b0;
                        r_state  <= ACQ;
                    end
                    ACQ: begin
                        if (w_ok) begin
                            r_good <= w_good_nx;
                            if (w_lock_hit) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_good <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_ok) begin
                            r_err_pulse <= 1'b1;
                            r_locked    <= 1'b0;
                            r_state     <= ERR;
                        end else begin
                            r_wrap_pulse <= w_wrap;
                        end
                    end
                    ERR: begin
                        r_good   <= '0;
                        r_locked <= 1'b0;
                        r_state  <= ACQ;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (clr),
        .i_inc (w_err_ev),
        .o_cnt (err_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (clr),
        .i_inc (w_wrap_ev),
        .o_cnt (wrap_count)
    );

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign last_delta = r_last_delta;

endmodule

// File: doc/dual_edge_count_checker.md
# dual_edge_count_checker

Single-clock receiver/checker for the 4-bit output of the dual-edge binary counter. It samples the counter value on every rising edge of `clk`. Because the counter advances on both edges, it expects a fixed increment of `STEP` per rising edge. It acquires lock, detects wrap-around and sequence errors, and keeps saturating event counters. It sits downstream of the counter, as the on-chip consumer and self-check of its output.

## Interface
Parameters:
- `WIDTH`, default 4: counter width; all deltas are computed modulo 2^WIDTH.
- `STEP`, default 2: expected increment per rising edge (two counter edges per `clk` period).
- `LOCK_CNT`, default 3: number of consecutive correct deltas required to lock (range 1..15).
- `CNT_W`, default 8: width of `err_count` and `wrap_count`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cnt_in` in WIDTH: counter value under check.
- `cnt_valid` in 1: high while the counter is out of reset and counting.
- `clr` in 1: synchronous clear of `err_count` and `wrap_count`.
- `locked` out 1: sequence verified and tracking.
- `err_pulse` out 1: one-cycle pulse on a sequence error while locked.
- `wrap_pulse` out 1: one-cycle pulse on a correct wrap while locked.
- `err_count` out CNT_W: saturating count of errors.
- `wrap_count` out CNT_W: saturating count of wraps.
- `last_delta` out WIDTH: value of `cnt_in - prev` mod 2^WIDTH from the most recent sample.

## Operation
- **State machine states:** IDLE, ACQ, LOCKED, ERR.
- **Internal registers:**
  - `prev` (WIDTH): previous sample.
  - `good` (4 bits): count of consecutive correct deltas.
- **Delta:** `delta = cnt_in - prev`, computed mod 2^WIDTH. A delta is correct when `delta == STEP`.
- **IDLE:**
  - `locked` = 0.
  - If `cnt_valid` = 1: `prev` ← `cnt_in`, `good` ← 0, go to ACQ.
- **ACQ:**
  - On a correct delta: `good` ← `good` + 1.
  - On an incorrect delta: `good` ← 0. No error is flagged.
  - `prev` ← `cnt_in` every cycle.
  - When `good` reaches `LOCK_CNT`: go to LOCKED.
- **LOCKED:**
  - `locked` = 1.
  - On an incorrect delta: `err_pulse`, `err_count` increments, go to ERR.
  - On a correct delta with `cnt_in < prev` (unsigned): `wrap_pulse`, `wrap_count` increments.
  - `prev` ← `cnt_in` every cycle.
- **ERR:**
  - Held for exactly one cycle with `locked` = 0.
  - `prev` ← `cnt_in`, `good` ← 0, then go to ACQ.
- **`cnt_valid` low:** in any state, go to IDLE at the next edge. No error is flagged and the counters hold their values.
- **`clr`:**
  - `clr` has priority over increments. Both counters go to 0.
  - An event in the same cycle as `clr` still pulses but is not counted.
- **Saturation:** `err_count` and `wrap_count` saturate at 2^CNT_W − 1 and never roll over.
- **`last_delta`:** updated on every cycle where `cnt_valid` = 1 and the state is not IDLE.

## Timing
- **Registered outputs:** all outputs are registered. An event sampled at edge N is visible from edge N through edge N+1.
- **Reset values** (on `rst` = 0, asserted asynchronously):
  - state = IDLE, `locked` = 0, `err_pulse` = 0, `wrap_pulse` = 0.
  - `err_count` = 0, `wrap_count` = 0, `last_delta` = 0.
  - `prev` = 0, `good` = 0.
- **Reset release:** synchronous in effect; the first rising edge after release can capture.
- **Lock latency:** with the first valid sample at edge k and correct deltas thereafter, `locked` rises after edge k + `LOCK_CNT`.
- **Error timing:** `locked` falls after the edge that samples the error, in the same cycle as `err_pulse`.
- **Relock after an error:** the earliest relock is after the edge at (error edge + 1 + `LOCK_CNT`).
- **Wrap:** `wrap_pulse` occurs only when locked. A wrap seen during ACQ is only a correct delta.
- **Reset mid-operation:** takes effect immediately, regardless of clock.

## Structure
- **Shared package** `dual_edge_pkg`:
  - state enum (IDLE, ACQ, LOCKED, ERR);
  - default constants `DEC_WIDTH=4`, `DEC_STEP=2`.
  - The counter and the checker both use this package.
- **Sub-module** `sat_counter`: parameterised CNT_W saturating incrementer with synchronous clear. It is instantiated twice, once for `err_count` and once for `wrap_count`.
- The delta, compare and state machine logic live in the top module.

## Test plan
All scenarios use WIDTH=4, STEP=2, LOCK_CNT=3, CNT_W=8 unless stated.
- **Reset:** assert `rst`=0 mid-cycle while LOCKED → immediately `locked`=0, `err_count`=0, `wrap_count`=0, `last_delta`=0.
- **Acquire:** `cnt_valid`=1, `cnt_in` = 0, 2, 4, 6 on consecutive edges → `locked`=1 after the edge sampling 6; `err_pulse` never asserted.
- **Wrap:** while locked, feed 12, 14, 0 → `wrap_pulse` for one cycle after the edge sampling 0, `wrap_count`=1, `last_delta`=2, `locked` stays 1.
- **Error and relock:** while locked, feed 6 then 9 → `err_pulse` for one cycle, `err_count`=1, `locked`=0. Then feed 11, 13, 15, 1 → relock after the edge sampling 1.
- **Counter reset mid-count:** drop `cnt_valid` with `cnt_in` forced to 0 for 2 cycles, then feed 0, 2, 4, 6 → no error counted and relock after 6. Repeat with the counter's own `rst` pulse sequence (reset for 10 ns at 5 ns half-period).
- **Clear and saturation:**
  - CNT_W=2 with 5 induced errors → `err_count` holds at 3.
  - `clr` in the same cycle as an error → `err_pulse`=1 and `err_count`=0.
